// File: rtl/ucontrol_collatz_if.sv
// Control/flag/handshake bundle between the Collatz microsequencer
// and the 8-bit register/ALU/shifter datapath plus the system side.
interface ucontrol_collatz_if #(
  parameter int DATAWIDTH_DECODER_SELECTION = 3,
  parameter int DATAWIDTH_MUX_SELECTION     = 3,
  parameter int DATAWIDTH_ALU_SELECTION     = 4
);
  logic uCONTROL_start_InHigh;
  logic uCONTROL_overflow_InLow;
  logic uCONTROL_carry_InLow;
  logic uCONTROL_negative_InLow;
  logic uCONTROL_zero_InLow;

  logic [DATAWIDTH_DECODER_SELECTION-1:0]
    uCONTROL_decoderclearselection_OutBUS;
  logic [DATAWIDTH_DECODER_SELECTION-1:0]
    uCONTROL_decoderloadselection_OutBUS;
  logic [DATAWIDTH_MUX_SELECTION-1:0]
    uCONTROL_muxselectionBUSA_OutBUS;
  logic [DATAWIDTH_MUX_SELECTION-1:0]
    uCONTROL_muxselectionBUSB_OutBUS;
  logic [DATAWIDTH_ALU_SELECTION-1:0]
    uCONTROL_aluselection_OutBUS;
  logic       uCONTROL_regSHIFTERclear_OutLow;
  logic       uCONTROL_regSHIFTERload_OutLow;
  logic [1:0] uCONTROL_regSHIFTERshiftselection_OutLow;
  logic       uCONTROL_busy_OutHigh;
  logic       uCONTROL_done_OutHigh;
  logic       uCONTROL_error_OutHigh;

  modport master (
    input  uCONTROL_start_InHigh,
    input  uCONTROL_overflow_InLow,
    input  uCONTROL_carry_InLow,
    input  uCONTROL_negative_InLow,
    input  uCONTROL_zero_InLow,
    output uCONTROL_decoderclearselection_OutBUS,
    output uCONTROL_decoderloadselection_OutBUS,
    output uCONTROL_muxselectionBUSA_OutBUS,
    output uCONTROL_muxselectionBUSB_OutBUS,
    output uCONTROL_aluselection_OutBUS,
    output uCONTROL_regSHIFTERclear_OutLow,
    output uCONTROL_regSHIFTERload_OutLow,
    output uCONTROL_regSHIFTERshiftselection_OutLow,
    output uCONTROL_busy_OutHigh,
    output uCONTROL_done_OutHigh,
    output uCONTROL_error_OutHigh
  );

  modport slave (
    output uCONTROL_start_InHigh,
    output uCONTROL_overflow_InLow,
    output uCONTROL_carry_InLow,
    output uCONTROL_negative_InLow,
    output uCONTROL_zero_InLow,
    input  uCONTROL_decoderclearselection_OutBUS,
    input  uCONTROL_decoderloadselection_OutBUS,
    input  uCONTROL_muxselectionBUSA_OutBUS,
    input  uCONTROL_muxselectionBUSB_OutBUS,
    input  uCONTROL_aluselection_OutBUS,
    input  uCONTROL_regSHIFTERclear_OutLow,
    input  uCONTROL_regSHIFTERload_OutLow,
    input  uCONTROL_regSHIFTERshiftselection_OutLow,
    input  uCONTROL_busy_OutHigh,
    input  uCONTROL_done_OutHigh,
    input  uCONTROL_error_OutHigh
  );
endinterface

// File: rtl/ucontrol_collatz.sv
// Microsequencer computing the Collatz step count of FIXED0 into R3
// by driving the register/ALU/shifter datapath one micro-op per cycle.
module ucontrol_collatz #(
  parameter int DATAWIDTH_DECODER_SELECTION = 3,
  parameter int DATAWIDTH_MUX_SELECTION     = 3,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter logic [3:0] ALU_OP_PASSA = 4'b0000,
  parameter logic [3:0] ALU_OP_ADD   = 4'b0001,
  parameter logic [3:0] ALU_OP_SUB   = 4'b0010,
  parameter logic [3:0] ALU_OP_AND   = 4'b0011,
  parameter logic [3:0] ALU_OP_INC   = 4'b0100,
  parameter logic [1:0] SHIFT_NONE   = 2'b11,
  parameter logic [1:0] SHIFT_RIGHT  = 2'b01,
  parameter logic [7:0] MAX_STEPS    = 8'd255
) (
  input logic uCONTROL_CLOCK_50,
  input logic uCONTROL_RESET_InLow,
  ucontrol_collatz_if.master bus
);

  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;

  localparam logic [DW-1:0] DEC_R0   = DW'(0);
  localparam logic [DW-1:0] DEC_R1   = DW'(1);
  localparam logic [DW-1:0] DEC_R2   = DW'(2);
  localparam logic [DW-1:0] DEC_R3   = DW'(3);
  localparam logic [DW-1:0] DEC_NONE = {DW{1'b1}};
  localparam logic [MW-1:0] MUX_R0   = MW'(0);
  localparam logic [MW-1:0] MUX_R1   = MW'(1);
  localparam logic [MW-1:0] MUX_R2   = MW'(2);
  localparam logic [MW-1:0] MUX_R3   = MW'(3);
  localparam logic [MW-1:0] MUX_FIX0 = MW'(4);

  typedef enum logic [4:0] {
    IDLE, EX_LDN, WB_LDN, CLR_R1, CLR_R3,
    EX_ONE, WB_ONE, EX_CHK1, EX_PAR,
    EX_HALF, SH_HALF, WB_HALF,
    EX_D2, WB_D2, EX_D3, WB_D3, EX_P1, WB_P1,
    EX_CNT, WB_CNT, DONE, ERR
  } state_t;

  typedef struct packed {
    logic [DW-1:0] dec_clr;
    logic [DW-1:0] dec_ld;
    logic [MW-1:0] mux_a;
    logic [MW-1:0] mux_b;
    logic [AW-1:0] alu;
    logic          sh_clr;
    logic          sh_ld;
    logic [1:0]    sh_sel;
    logic          busy;
    logic          done;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic [7:0] steps_q, steps_d;
  logic err_q, err_d;
  logic start, zero, carry;
  logic unused_flags;

  assign start = bus.uCONTROL_start_InHigh;
  assign zero  = ~bus.uCONTROL_zero_InLow;
  assign carry = ~bus.uCONTROL_carry_InLow;
  assign unused_flags = bus.uCONTROL_negative_InLow
                      ^ bus.uCONTROL_overflow_InLow;

  always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_RESET_InLow) begin
    if (!uCONTROL_RESET_InLow) begin
      state_q        <= IDLE;
      steps_q        <= '0;
      err_q          <= 1'b0;
      ctrl_q.dec_clr <= DEC_NONE;
      ctrl_q.dec_ld  <= DEC_NONE;
      ctrl_q.mux_a   <= '0;
      ctrl_q.mux_b   <= '0;
      ctrl_q.alu     <= AW'(ALU_OP_PASSA);
      ctrl_q.sh_clr  <= 1'b1;
      ctrl_q.sh_ld   <= 1'b1;
      ctrl_q.sh_sel  <= SHIFT_NONE;
      ctrl_q.busy    <= 1'b0;
      ctrl_q.done    <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Flags are live for the EX cycle presenting them; branch on them here.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EX_LDN;
      EX_LDN:  state_d = zero ? ERR : WB_LDN;
      WB_LDN:  state_d = CLR_R1;
      CLR_R1:  state_d = CLR_R3;
      CLR_R3:  state_d = EX_ONE;
      EX_ONE:  state_d = WB_ONE;
      WB_ONE:  state_d = EX_CHK1;
      EX_CHK1: state_d = zero ? DONE : EX_PAR;
      EX_PAR:  state_d = zero ? EX_HALF : EX_D2;
      EX_HALF: state_d = SH_HALF;
      SH_HALF: state_d = WB_HALF;
      WB_HALF: state_d = EX_CNT;
      EX_D2:   state_d = carry ? ERR : WB_D2;
      WB_D2:   state_d = EX_D3;
      EX_D3:   state_d = carry ? ERR : WB_D3;
      WB_D3:   state_d = EX_P1;
      EX_P1:   state_d = carry ? ERR : WB_P1;
      WB_P1:   state_d = EX_CNT;
      EX_CNT:  state_d = WB_CNT;
      WB_CNT:  state_d = (steps_q == MAX_STEPS) ? ERR : EX_CHK1;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    steps_d = steps_q;
    err_d   = err_q;
    if (state_q == IDLE && start) begin
      steps_d = '0;
      err_d   = 1'b0;
    end else if (state_q == EX_CNT) begin
      steps_d = steps_q + 8'd1;
    end
    if (state_d == ERR) err_d = 1'b1;
  end

  // Controls are decoded from the next state so the registered copy
  // matches the state during the cycle it is presented.
  always_comb begin
    ctrl_d.dec_clr = DEC_NONE;
    ctrl_d.dec_ld  = DEC_NONE;
    ctrl_d.mux_a   = '0;
    ctrl_d.mux_b   = '0;
    ctrl_d.alu     = AW'(ALU_OP_PASSA);
    ctrl_d.sh_clr  = 1'b1;
    ctrl_d.sh_ld   = 1'b1;
    ctrl_d.sh_sel  = SHIFT_NONE;
    ctrl_d.busy    = 1'b1;
    ctrl_d.done    = 1'b0;
    unique case (state_d)
      IDLE: ctrl_d.busy = 1'b0;
      EX_LDN: begin
        ctrl_d.mux_a = MUX_FIX0;
        ctrl_d.sh_ld = 1'b0;
      end
      WB_LDN: ctrl_d.dec_ld  = DEC_R0;
      CLR_R1: ctrl_d.dec_clr = DEC_R1;
      CLR_R3: ctrl_d.dec_clr = DEC_R3;
      EX_ONE: begin
        ctrl_d.mux_a = MUX_R1;
        ctrl_d.alu   = AW'(ALU_OP_INC);
        ctrl_d.sh_ld = 1'b0;
      end
      WB_ONE: ctrl_d.dec_ld = DEC_R1;
      EX_CHK1: begin
        ctrl_d.mux_a = MUX_R0;
        ctrl_d.mux_b = MUX_R1;
        ctrl_d.alu   = AW'(ALU_OP_SUB);
      end
      EX_PAR: begin
        ctrl_d.mux_a = MUX_R0;
        ctrl_d.mux_b = MUX_R1;
        ctrl_d.alu   = AW'(ALU_OP_AND);
      end
      EX_HALF: begin
        ctrl_d.mux_a = MUX_R0;
        ctrl_d.sh_ld = 1'b0;
      end
      SH_HALF: ctrl_d.sh_sel = SHIFT_RIGHT;
      WB_HALF: ctrl_d.dec_ld = DEC_R0;
      EX_D2: begin
        ctrl_d.mux_a = MUX_R0;
        ctrl_d.mux_b = MUX_R0;
        ctrl_d.alu   = AW'(ALU_OP_ADD);
        ctrl_d.sh_ld = 1'b0;
      end
      WB_D2: ctrl_d.dec_ld = DEC_R2;
      EX_D3: begin
        ctrl_d.mux_a = MUX_R2;
        ctrl_d.mux_b = MUX_R0;
        ctrl_d.alu   = AW'(ALU_OP_ADD);
        ctrl_d.sh_ld = 1'b0;
      end
      WB_D3: ctrl_d.dec_ld = DEC_R2;
      EX_P1: begin
        ctrl_d.mux_a = MUX_R2;
        ctrl_d.alu   = AW'(ALU_OP_INC);
        ctrl_d.sh_ld = 1'b0;
      end
      WB_P1: ctrl_d.dec_ld = DEC_R0;
      EX_CNT: begin
        ctrl_d.mux_a = MUX_R3;
        ctrl_d.alu   = AW'(ALU_OP_INC);
        ctrl_d.sh_ld = 1'b0;
      end
      WB_CNT: ctrl_d.dec_ld = DEC_R3;
      DONE, ERR: begin
        ctrl_d.busy = 1'b0;
        ctrl_d.done = 1'b1;
      end
      default: ctrl_d.busy = 1'b0;
    endcase
  end

  assign bus.uCONTROL_decoderclearselection_OutBUS    = ctrl_q.dec_clr;
  assign bus.uCONTROL_decoderloadselection_OutBUS     = ctrl_q.dec_ld;
  assign bus.uCONTROL_muxselectionBUSA_OutBUS         = ctrl_q.mux_a;
  assign bus.uCONTROL_muxselectionBUSB_OutBUS         = ctrl_q.mux_b;
  assign bus.uCONTROL_aluselection_OutBUS             = ctrl_q.alu;
  assign bus.uCONTROL_regSHIFTERclear_OutLow          = ctrl_q.sh_clr;
  assign bus.uCONTROL_regSHIFTERload_OutLow           = ctrl_q.sh_ld;
  assign bus.uCONTROL_regSHIFTERshiftselection_OutLow = ctrl_q.sh_sel;
  assign bus.uCONTROL_busy_OutHigh                    = ctrl_q.busy;
  assign bus.uCONTROL_done_OutHigh                    = ctrl_q.done;
  assign bus.uCONTROL_error_OutHigh                   = err_q;

endmodule

// File: tb/tb_ucontrol_collatz.sv
// Bench for ucontrol_collatz: a behavioural datapath closes the loop,
// a scoreboard checks every completed run against directed expectations.
module tb_ucontrol_collatz;

  typedef struct {
    int n;
    int r3;
    int err;
    int cyc;
    int lds;
    int r0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preset = 1'b0;
  logic [7:0] n_val = 8'd0;
  logic [7:0] r [4];
  logic [7:0] sh;
  logic [7:0] a, b;
  logic [8:0] res;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  exp_t sbq[$];

  ucontrol_collatz_if bus ();

  ucontrol_collatz dut (
    .uCONTROL_CLOCK_50(clk),
    .uCONTROL_RESET_InLow(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src(input logic [2:0] sel);
    case (sel)
      3'd0: return r[0];
      3'd1: return r[1];
      3'd2: return r[2];
      3'd3: return r[3];
      3'd4: return n_val;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    a   = src(bus.uCONTROL_muxselectionBUSA_OutBUS);
    b   = src(bus.uCONTROL_muxselectionBUSB_OutBUS);
    res = 9'd0;
    case (bus.uCONTROL_aluselection_OutBUS)
      4'b0000: res = {1'b0, a};
      4'b0001: res = {1'b0, a} + {1'b0, b};
      4'b0010: res = {1'b0, a} - {1'b0, b};
      4'b0011: res = {1'b0, a & b};
      4'b0100: res = {1'b0, a} + 9'd1;
      default: res = 9'd0;
    endcase
  end

  assign bus.uCONTROL_zero_InLow     = ~(res[7:0] == 8'd0);
  assign bus.uCONTROL_carry_InLow    = ~res[8];
  assign bus.uCONTROL_negative_InLow = ~res[7];
  assign bus.uCONTROL_overflow_InLow = 1'b1;

  always @(posedge clk) begin
    if (preset) begin
      r[0] <= 8'h5A;
      r[3] <= 8'hA5;
    end else begin
      if (bus.uCONTROL_decoderclearselection_OutBUS != 3'b111)
        r[bus.uCONTROL_decoderclearselection_OutBUS[1:0]] <= 8'd0;
      if (bus.uCONTROL_decoderloadselection_OutBUS != 3'b111)
        r[bus.uCONTROL_decoderloadselection_OutBUS[1:0]] <= sh;
    end
    if (!bus.uCONTROL_regSHIFTERclear_OutLow)
      sh <= 8'd0;
    else if (!bus.uCONTROL_regSHIFTERload_OutLow)
      sh <= res[7:0];
    else if (bus.uCONTROL_regSHIFTERshiftselection_OutLow == 2'b01)
      sh <= sh >> 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int n, input int r3, input int err,
                              input int cyc, input int lds, input int r0);
    exp_t e;
    e.n = n; e.r3 = r3; e.err = err;
    e.cyc = cyc; e.lds = lds; e.r0 = r0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  initial begin
    int busy_c;
    int ld_c;
    int prev;
    exp_t e;
    busy_c = 0; ld_c = 0; prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_c = 0; ld_c = 0; prev = 0;
      end else begin
        if (bus.uCONTROL_busy_OutHigh) busy_c++;
        if (bus.uCONTROL_decoderloadselection_OutBUS == 3'd3) ld_c++;
        if (bus.uCONTROL_done_OutHigh) begin
          chk("done_width", prev, 0);
          chk("sb_pending", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("r3 n=%0d", e.n), int'(r[3]), e.r3);
            chk($sformatf("err n=%0d", e.n),
                int'(bus.uCONTROL_error_OutHigh), e.err);
            chk($sformatf("r3_loads n=%0d", e.n), ld_c, e.lds);
            if (e.cyc >= 0)
              chk($sformatf("busy_cyc n=%0d", e.n), busy_c, e.cyc);
            if (e.r0 >= 0)
              chk($sformatf("r0 n=%0d", e.n), int'(r[0]), e.r0);
          end
          busy_c = 0; ld_c = 0;
          done_cnt++;
        end
        prev = int'(bus.uCONTROL_done_OutHigh);
      end
    end
  end

  task automatic start_run(input exp_t e);
    n_val = 8'(e.n);
    sbq.push_back(e);
    @(posedge clk);
    #1 preset = 1'b1;
    bus.uCONTROL_start_InHigh = 1'b1;
    @(posedge clk);
    #1 preset = 1'b0;
    bus.uCONTROL_start_InHigh = 1'b0;
  endtask

  task automatic wait_done();
    int c0;
    int cyc;
    c0 = done_cnt;
    cyc = 0;
    while (done_cnt == c0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_cnt == c0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done want done");
    end
  endtask

  exp_t vec [9];

  initial begin
    vec[0] = mk(1,   0,     0, 7,   0,  -1);
    vec[1] = mk(2,   1,     0, 14,  1,  -1);
    vec[2] = mk(3,   7,     0, 62,  7,  -1);
    vec[3] = mk(6,   8,     0, 69,  8,  -1);
    vec[4] = mk(128, 7,     0, 56,  7,  -1);
    vec[5] = mk(0,   8'hA5, 1, -1,  0,  8'h5A);
    vec[6] = mk(85,  0,     1, -1,  0,  85);
    vec[7] = mk(129, 0,     1, -1,  0,  129);
    vec[8] = mk(27,  11,    1, -1,  11, 107);

    bus.uCONTROL_start_InHigh = 1'b1;
    n_val = 8'd1;
    preset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_clr", int'(bus.uCONTROL_decoderclearselection_OutBUS), 7);
    chk("rst_dec_ld", int'(bus.uCONTROL_decoderloadselection_OutBUS), 7);
    chk("rst_mux_a", int'(bus.uCONTROL_muxselectionBUSA_OutBUS), 0);
    chk("rst_mux_b", int'(bus.uCONTROL_muxselectionBUSB_OutBUS), 0);
    chk("rst_alu", int'(bus.uCONTROL_aluselection_OutBUS), 0);
    chk("rst_sh_clr", int'(bus.uCONTROL_regSHIFTERclear_OutLow), 1);
    chk("rst_sh_ld", int'(bus.uCONTROL_regSHIFTERload_OutLow), 1);
    chk("rst_sh_sel",
        int'(bus.uCONTROL_regSHIFTERshiftselection_OutLow), 3);
    chk("rst_busy", int'(bus.uCONTROL_busy_OutHigh), 0);
    chk("rst_done", int'(bus.uCONTROL_done_OutHigh), 0);
    chk("rst_error", int'(bus.uCONTROL_error_OutHigh), 0);

    sbq.push_back(vec[0]);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("held_start_busy", int'(bus.uCONTROL_busy_OutHigh), 1);
    chk("held_start_mux_a", int'(bus.uCONTROL_muxselectionBUSA_OutBUS), 4);
    bus.uCONTROL_start_InHigh = 1'b0;
    preset = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      start_run(vec[i]);
      wait_done();
      repeat (5) @(posedge clk);
      #1 chk($sformatf("idle_after n=%0d", vec[i].n),
             int'(bus.uCONTROL_busy_OutHigh), 0);
    end

    // Start pulse while busy must be ignored.
    start_run(mk(7, 16, 0, 134, 16, -1));
    repeat (40) @(posedge clk);
    #1 bus.uCONTROL_start_InHigh = 1'b1;
    @(posedge clk);
    #1 bus.uCONTROL_start_InHigh = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    #1 chk("no_restart_busy", int'(bus.uCONTROL_busy_OutHigh), 0);
    chk("sb_empty", sbq.size(), 0);

    // Start held across DONE restarts immediately.
    n_val = 8'd1;
    sbq.push_back(mk(1, 0, 0, 7, 0, -1));
    sbq.push_back(mk(1, 0, 0, 7, 0, -1));
    @(posedge clk);
    #1 bus.uCONTROL_start_InHigh = 1'b1;
    wait_done();
    wait_done();
    #1 bus.uCONTROL_start_InHigh = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("held_restart_count", sbq.size(), 0);

    // Reset mid-run aborts at once.
    start_run(mk(7, 16, 0, 134, 16, -1));
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("abort_busy", int'(bus.uCONTROL_busy_OutHigh), 0);
    chk("abort_dec_ld", int'(bus.uCONTROL_decoderloadselection_OutBUS), 7);
    chk("abort_sh_ld", int'(bus.uCONTROL_regSHIFTERload_OutLow), 1);
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_run(vec[3]);
    wait_done();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
